display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 126 ++++++++++++
 tb/tb_display_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : display_scanner
// Brief    : Sequential binary-to-BCD converter feeding a 4-digit multiplexed
//            7-segment scanner with optional leading-zero blanking.
// Revision : 1.0
// ============================================================================
module display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic [7:0]  digit_out,
  output logic [3:0]  anode
);

  localparam int                  c_pre_w     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(REFRESH_DIV - 1);
  localparam logic [3:0]          c_iter_last = 4'd13;
  localparam logic [13:0]         c_max_val   = 14'd9999;

  logic               r_busy;
  logic [3:0]         r_iter;
  logic [13:0]        r_bin;
  logic [15:0]        r_bcd;
  logic               r_ovf_cap;
  logic [15:0]        r_dig;
  logic               r_ovf;
  logic [c_pre_w-1:0] r_pre;
  logic [1:0]         r_idx;
  logic [3:0]         r_anode;
  logic [7:0]         r_dout;

  logic [14:0]        w_bcd_adj;
  logic [15:0]        w_bcd_next;
  logic               w_commit;
  logic               w_wrap;
  logic [1:0]         w_idx_next;
  logic [15:0]        w_dig_src;
  logic               w_ovf_src;
  logic [1:0]         w_msd;
  logic               w_blank;
  logic [3:0]         w_nibble;
  logic [3:0]         w_anode_next;
  logic [7:0]         w_dout_next;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_adj
      assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? (r_bcd[4*g +: 4] + 4'd3)
                                                              : r_bcd[4*g +: 4];
    end
  endgenerate

  // Thousands nibble: its top bit is shifted out, so only the low three bits are kept.
  assign w_bcd_adj[14:12] = (r_bcd[15:12] >= 4'd5) ? (r_bcd[14:12] + 3'd3) : r_bcd[14:12];
  assign w_bcd_next       = {w_bcd_adj, r_bin[13]};

  assign w_commit   = r_busy && (r_iter == c_iter_last);
  assign w_wrap     = (r_pre == c_pre_last);
  assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

  // Output register is refreshed from the result being committed this cycle, if any.
  assign w_dig_src  = w_commit ? w_bcd_next : r_dig;
  assign w_ovf_src  = w_commit ? r_ovf_cap  : r_ovf;

  always_comb begin
    w_msd = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_dig_src[4*i +: 4] != 4'd0) w_msd = 2'(i);
    end
  end

  assign w_blank      = BLANK_LZ && !w_ovf_src && (w_idx_next > w_msd);
  assign w_nibble     = w_dig_src[{w_idx_next, 2'b00} +: 4];
  assign w_anode_next = w_blank ? 4'b1111 : ~(4'b0001 << w_idx_next);
  assign w_dout_next  = w_ovf_src ? 8'hFF : (w_blank ? 8'h00 : {4'h0, w_nibble});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_iter    <= 4'd0;
      r_bin     <= 14'd0;
      r_bcd     <= 16'd0;
      r_ovf_cap <= 1'b0;
      r_dig     <= 16'd0;
      r_ovf     <= 1'b0;
      r_pre     <= '0;
      r_idx     <= 2'd0;
      r_anode   <= 4'b1110;
      r_dout    <= 8'h00;
    end else begin
      r_pre <= w_wrap ? '0 : (r_pre + c_pre_w'(1));
      r_idx <= w_idx_next;
      if (w_wrap || w_commit) begin
        r_anode <= w_anode_next;
        r_dout  <= w_dout_next;
      end
      if (r_busy) begin
        r_bcd  <= w_bcd_next;
        r_bin  <= {r_bin[12:0], 1'b0};
        r_iter <= r_iter + 4'd1;
        if (w_commit) begin
          r_busy <= 1'b0;
          r_dig  <= w_bcd_next;
          r_ovf  <= r_ovf_cap;
        end
      end else if (load) begin
        r_bin     <= value;
        r_bcd     <= 16'd0;
        r_iter    <= 4'd0;
        r_ovf_cap <= (value > c_max_val);
        r_busy    <= 1'b1;
      end
    end
  end

  assign busy      = r_busy;
  assign anode     = r_anode;
  assign digit_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scanner
// Brief    : Directed self-checking bench for display_scanner (REFRESH_DIV=4).
// Revision : 1.0
// ============================================================================
module tb_display_scanner;

  localparam int c_div = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] value = 14'd0;
  logic        busy;
  logic [7:0]  digit_out;
  logic [3:0]  anode;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] e_bcd = 16'h0000;
  logic        e_ovf = 1'b0;

  display_scanner #(.REFRESH_DIV(c_div), .BLANK_LZ(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .busy      (busy),
    .digit_out (digit_out),
    .anode     (anode)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan index is (cyc / c_div) % 4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int msd_of(input logic [15:0] d);
    int m = 0;
    for (int i = 1; i < 4; i++) if (d[4*i +: 4] != 4'd0) m = i;
    return m;
  endfunction

  function automatic logic [3:0] exp_anode(input int idx);
    if (!e_ovf && idx > msd_of(e_bcd)) return 4'b1111;
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [7:0] exp_dout(input int idx);
    if (e_ovf) return 8'hFF;
    if (idx > msd_of(e_bcd)) return 8'h00;
    return {4'h0, e_bcd[4*idx +: 4]};
  endfunction

  task automatic check_display(input string tag);
    int idx = (cyc / c_div) % 4;
    check({tag, "_anode"}, {28'd0, anode}, {28'd0, exp_anode(idx)});
    check({tag, "_digit"}, {24'd0, digit_out}, {24'd0, exp_dout(idx)});
  endtask

  task automatic scan(input string tag);
    repeat (4 * c_div) begin
      @(negedge clk);
      check_display(tag);
    end
  endtask

  // Launch a conversion; optionally inject a second load mid-busy or hold load as a level.
  task automatic do_load(input logic [13:0] v, input logic [15:0] bcd, input logic ovf,
                         input int inj_at, input logic [13:0] inj_v, input bit hold);
    int n = 0;
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = hold;
    while (busy && n < 40) begin
      n++;
      check_display("hold_prev");
      if (n == inj_at) begin
        load  = 1'b1;
        value = inj_v;
      end else begin
        load = hold;
      end
      @(negedge clk);
    end
    check("busy_len", n, 14);
    e_bcd = bcd;
    e_ovf = ovf;
    check_display("commit");
    if (hold) begin
      @(negedge clk);
      load = 1'b0;
      check("relaunch", {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("busy_len2", n, 14);
    end
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_anode", {28'd0, anode}, 32'h0000_000E);
    check("rst_digit", {24'd0, digit_out}, 32'h0000_0000);
    rst = 1'b0;
    scan("zero");

    do_load(14'd1234, 16'h1234, 1'b0, 0, 14'd0, 1'b0);
    scan("v1234");
    do_load(14'd7, 16'h0007, 1'b0, 0, 14'd0, 1'b0);
    scan("v7");
    do_load(14'd0, 16'h0000, 1'b0, 0, 14'd0, 1'b0);
    scan("v0");
    do_load(14'd9999, 16'h9999, 1'b0, 0, 14'd0, 1'b0);
    scan("v9999");
    do_load(14'd10000, 16'h0000, 1'b1, 0, 14'd0, 1'b0);
    scan("v10000");
    do_load(14'd1234, 16'h1234, 1'b0, 5, 14'd5678, 1'b0);
    scan("ignore5678");
    do_load(14'd305, 16'h0305, 1'b0, 0, 14'd0, 1'b1);
    scan("v305");

    // Abort a conversion of 4321 with reset at cycle 7 of busy.
    @(negedge clk);
    value = 14'd4321;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_anode", {28'd0, anode}, 32'h0000_000E);
    check("abort_digit", {24'd0, digit_out}, 32'h0000_0000);
    e_bcd = 16'h0000;
    e_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    scan("post_abort");
    do_load(14'd42, 16'h0042, 1'b0, 0, 14'd0, 1'b0);
    scan("v42");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
